// File: rtl/mio_axis_fifo.sv
// mio_axis_fifo: AXI4-Stream synchronous FIFO, registered outputs, full sideband.
// Define MIO_AXIS_FIFO_PKT_MODE_EN for store-and-forward with a full-FIFO cut-through escape.
module mio_axis_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 4,
   parameter int USER_WIDTH = 1,
   parameter int DEPTH      = 16
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic                        s_tvalid,
   output logic                        s_tready,
   input  logic [DATA_WIDTH-1:0]       s_tdata,
   input  logic [DATA_WIDTH/8-1:0]     s_tstrb,
   input  logic [DATA_WIDTH/8-1:0]     s_tkeep,
   input  logic                        s_tlast,
   input  logic [ID_WIDTH-1:0]         s_tid,
   input  logic [DEST_WIDTH-1:0]       s_tdest,
   input  logic [USER_WIDTH-1:0]       s_tuser,
   output logic                        m_tvalid,
   input  logic                        m_tready,
   output logic [DATA_WIDTH-1:0]       m_tdata,
   output logic [DATA_WIDTH/8-1:0]     m_tstrb,
   output logic [DATA_WIDTH/8-1:0]     m_tkeep,
   output logic                        m_tlast,
   output logic [ID_WIDTH-1:0]         m_tid,
   output logic [DEST_WIDTH-1:0]       m_tdest,
   output logic [USER_WIDTH-1:0]       m_tuser,
   output logic [$clog2(DEPTH):0]      level
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = DATA_WIDTH + 2 * NB + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
   logic [PW-1:0] mem [DEPTH];
   logic [PW-1:0] s_pay, m_pay, head;
   logic [LW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, lvl_nxt;
   logic          push, pop, full_nxt, v_nxt;
   assign s_pay = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
   assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = m_pay;
   assign push     = s_tvalid & s_tready;
   assign pop      = m_tvalid & m_tready;
   assign wr_nxt   = wr_ptr + LW'(push);
   assign rd_nxt   = rd_ptr + LW'(pop);
   assign lvl_nxt  = wr_nxt - rd_nxt;
   assign level    = wr_ptr - rd_ptr;
   assign full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
   // The next head is the incoming beat when the slot it lands in is the one being presented
   assign head = (push && rd_nxt == wr_ptr) ? s_pay : mem[rd_nxt[AW-1:0]];
`ifdef MIO_AXIS_FIFO_PKT_MODE_EN
   logic [LW-1:0] pkt_cnt, pkt_nxt;
   logic          esc, esc_nxt;
   assign pkt_nxt = pkt_cnt + LW'(push && s_tlast) - LW'(pop && m_tlast);
   // Escape latches on full and holds until the oversized packet's tlast beat leaves
   assign esc_nxt = full_nxt || (esc && !(pop && m_tlast));
   assign v_nxt   = (lvl_nxt != '0) && ((pkt_nxt != '0) || esc_nxt);
   always_ff @(posedge aclk) begin
      if (areset) begin
         pkt_cnt <= '0;
         esc     <= 1'b0;
      end else begin
         pkt_cnt <= pkt_nxt;
         esc     <= esc_nxt;
      end
   end
`else
   assign v_nxt = lvl_nxt != '0;
`endif
   always_ff @(posedge aclk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= s_pay;
   end
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         s_tready <= 1'b0;
         m_tvalid <= 1'b0;
         m_pay    <= '0;
      end else begin
         wr_ptr   <= wr_nxt;
         rd_ptr   <= rd_nxt;
         s_tready <= !full_nxt;
         m_tvalid <= v_nxt;
         if (v_nxt && (pop || !m_tvalid)) m_pay <= head;
      end
   end
endmodule

// File: tb/tb_mio_axis_fifo.sv
// tb_mio_axis_fifo: directed table plus random backpressure against a queue reference model.
// Build with MIO_AXIS_FIFO_PKT_MODE_EN to also exercise store-and-forward.
module tb_mio_axis_fifo;
   localparam int DEPTH = 16;
   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  strb;
      logic [3:0]  keep;
      logic        last;
      logic [7:0]  id;
      logic [3:0]  dest;
      logic [0:0]  user;
   } beat_t;
   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        r;
      logic        ev;
      logic [4:0]  el;
      logic        er;
      logic [31:0] ed;
   } vec_t;
   logic        aclk = 1'b0, areset = 1'b1;
   logic        s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
   logic [31:0] s_tdata, m_tdata;
   logic [3:0]  s_tstrb, s_tkeep, m_tstrb, m_tkeep, s_tdest, m_tdest;
   logic [7:0]  s_tid, m_tid;
   logic [0:0]  s_tuser, m_tuser;
   logic [4:0]  level;
   beat_t       m_beat, last_pay;
   beat_t       q[$];
   logic        exp_rdy = 1'b0, exp_v = 1'b0;
`ifdef MIO_AXIS_FIFO_PKT_MODE_EN
   logic        esc = 1'b0;
`endif
   int          tests = 0, fails = 0, n_push = 0;
   vec_t        tbl[7];
   always #5 aclk = ~aclk;
   assign m_beat = {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
   mio_axis_fifo dut (
      .aclk(aclk), .areset(areset),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
      .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
      .level(level)
   );
   task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
      end
   endtask
   function automatic beat_t rnd_beat(input logic last);
      beat_t b;
      b.d = $urandom; b.strb = 4'($urandom); b.keep = 4'($urandom);
      b.id = 8'($urandom); b.dest = 4'($urandom); b.user = 1'($urandom); b.last = last;
      return b;
   endfunction
   function automatic beat_t plain_beat(input logic [31:0] d);
      beat_t b = '0;
      b.d = d; b.last = 1'b1;
      return b;
   endfunction
   task automatic drv(input logic v, input beat_t b, input logic r);
      s_tvalid = v;
      {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser} = b;
      m_tready = r;
   endtask
   // One clock: apply the AXIS handshake rules to the queue, then compare every output
   task automatic tick();
      logic  push, pop;
      beat_t b, popped;
      push = s_tvalid && exp_rdy && !areset;
      pop  = exp_v && m_tready && !areset;
      b    = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
      @(posedge aclk);
      #1;
      if (areset) begin
         q.delete();
         exp_rdy  = 1'b0;
         last_pay = '0;
`ifdef MIO_AXIS_FIFO_PKT_MODE_EN
         esc = 1'b0;
`endif
      end else begin
         if (pop) begin
            popped = q.pop_front();
`ifdef MIO_AXIS_FIFO_PKT_MODE_EN
            if (popped.last) esc = 1'b0;
`endif
         end
         if (push) begin
            q.push_back(b);
            n_push++;
         end
`ifdef MIO_AXIS_FIFO_PKT_MODE_EN
         if (q.size() == DEPTH) esc = 1'b1;
`endif
         exp_rdy = q.size() < DEPTH;
      end
`ifdef MIO_AXIS_FIFO_PKT_MODE_EN
      exp_v = 1'b0;
      foreach (q[i]) if (q[i].last) exp_v = 1'b1;
      exp_v = q.size() > 0 && (exp_v || esc);
`else
      exp_v = q.size() > 0;
`endif
      if (exp_v) last_pay = q[0];
      chk("s_tready", 64'(s_tready), 64'(exp_rdy));
      chk("m_tvalid", 64'(m_tvalid), 64'(exp_v));
      chk("level", 64'(level), 64'(q.size()));
      chk("payload", 64'(m_beat), 64'(last_pay));
   endtask
   initial begin
      int start;
      tbl[0] = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 5'd1, 1'b1, 32'hA5A5_0001};
      tbl[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0, 1'b1, 32'hA5A5_0001};
      tbl[2] = '{1'b1, 32'h11,        1'b0, 1'b1, 5'd1, 1'b1, 32'h11};
      tbl[3] = '{1'b1, 32'h22,        1'b0, 1'b1, 5'd2, 1'b1, 32'h11};
      tbl[4] = '{1'b1, 32'h33,        1'b1, 1'b1, 5'd2, 1'b1, 32'h22};
      tbl[5] = '{1'b0, 32'h0,         1'b1, 1'b1, 5'd1, 1'b1, 32'h33};
      tbl[6] = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0, 1'b1, 32'h33};
      drv(1'b0, '0, 1'b0);
      tick();
      tick();
      chk("rst_data", 64'(m_tdata), 64'd0);
      areset = 1'b0;
      tick();
      chk("rdy_after_rst", 64'(s_tready), 64'd1);
      for (int i = 0; i < 7; i++) begin
         drv(tbl[i].v, plain_beat(tbl[i].d), tbl[i].r);
         tick();
         chk($sformatf("tbl%0d_valid", i), 64'(m_tvalid), 64'(tbl[i].ev));
         chk($sformatf("tbl%0d_level", i), 64'(level), 64'(tbl[i].el));
         chk($sformatf("tbl%0d_ready", i), 64'(s_tready), 64'(tbl[i].er));
         chk($sformatf("tbl%0d_data", i), 64'(m_tdata), 64'(tbl[i].ed));
      end
      for (int i = 0; i < 20; i++) begin
         drv(1'b1, rnd_beat(1'($urandom_range(0, 3) == 0)), 1'b0);
         tick();
      end
      chk("fill_level", 64'(level), 64'd16);
      chk("fill_ready", 64'(s_tready), 64'd0);
      for (int i = 0; i < 20; i++) begin
         drv(1'b0, '0, 1'b1);
         tick();
      end
      chk("fill_drained", 64'(level), 64'd0);
      for (int i = 0; i < 100; i++) begin
         drv(1'b1, rnd_beat(1'b1), 1'b1);
         tick();
         if (i > 0) chk("stream_level", 64'(level), 64'd1);
      end
      for (int i = 0; i < 3; i++) begin
         drv(1'b0, '0, 1'b1);
         tick();
      end
      start = n_push;
      for (int i = 0; i < 6000 && n_push - start < 1000; i++) begin
         drv(1'($urandom), rnd_beat(1'($urandom_range(0, 3) == 0)), 1'($urandom));
         tick();
      end
      chk("rand_beats", 64'(n_push - start >= 1000), 64'd1);
      start = n_push;
      for (int i = 0; i < 40; i++) begin
         drv(n_push == start, rnd_beat(1'b1), 1'b1);
         tick();
      end
      chk("rand_drained", 64'(level), 64'd0);
      for (int i = 0; i < 7; i++) begin
         drv(1'b1, rnd_beat(1'b0), 1'b0);
         tick();
      end
      chk("pre_rst_level", 64'(level), 64'd7);
      areset = 1'b1;
      drv(1'b0, '0, 1'b0);
      tick();
      chk("midrst_valid", 64'(m_tvalid), 64'd0);
      chk("midrst_level", 64'(level), 64'd0);
      areset = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, rnd_beat(i == 3), 1'b1);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         drv(1'b0, '0, 1'b1);
         tick();
      end
      chk("post_rst_drained", 64'(level), 64'd0);
`ifdef MIO_AXIS_FIFO_PKT_MODE_EN
      for (int k = 0; k < 4; k++) begin
         drv(1'b1, rnd_beat(k == 3), 1'b1);
         tick();
         chk("pkt_gate", 64'(m_tvalid), 64'(k == 3));
         drv(1'b0, '0, 1'b1);
         tick();
      end
      for (int i = 0; i < 6; i++) tick();
      start = n_push;
      for (int i = 0; i < 60; i++) begin
         drv(n_push - start < 20, rnd_beat(n_push - start == 19), 1'b1);
         tick();
         if (level == 5'd16) chk("pkt_escape", 64'(m_tvalid), 64'd1);
      end
      chk("pkt_long_drained", 64'(level), 64'd0);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
